// File: rtl/fork_join_ctrl.sv
// Fork/join launcher: forks NUM_CH timed jobs, joins per mode (ALL/ANY/NONE), runs a tail job, drains.
// Optional `abort`/`aborted` ports are compiled in when FJC_ABORT_EN is defined.
module fork_join_ctrl #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [NUM_CH*CNT_W-1:0] dur,
    input  logic [CNT_W-1:0]        tail_dur,
`ifdef FJC_ABORT_EN
    input  logic                    abort,
    output logic                    aborted,
`endif
    output logic                    busy,
    output logic [NUM_CH-1:0]       ch_active,
    output logic [NUM_CH-1:0]       ch_done,
    output logic                    join_pulse,
    output logic                    tail_active,
    output logic                    tail_done,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, FORK, TAIL, DRAIN} state_t;

    state_t           state;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] tail_len;
    logic [CNT_W-1:0] tail_cnt;
    logic [CNT_W-1:0] ch_cnt [NUM_CH];
    logic [NUM_CH-1:0] ch_cmp;
    logic             all_cmp;
    logic             any_cmp;
    logic             join_ok;

    // A channel counts as complete from its ch_done cycle (count of 1) onward.
    always_comb begin
        ch_cmp    = '0;
        ch_active = '0;
        ch_done   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_cmp[i]    = (ch_cnt[i] <= CNT_W'(1));
            ch_active[i] = (ch_cnt[i] != '0);
            ch_done[i]   = (ch_cnt[i] == CNT_W'(1));
        end
        all_cmp = &ch_cmp;
        any_cmp = |ch_cmp;
        case (mode_q)
            2'b01:   join_ok = any_cmp;
            2'b10:   join_ok = 1'b1;
            default: join_ok = all_cmp;
        endcase
        tail_active = (tail_cnt != '0);
        tail_done   = (tail_cnt == CNT_W'(1));
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= '0;
            tail_len   <= '0;
            tail_cnt   <= '0;
            join_pulse <= 1'b0;
            done       <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) ch_cnt[i] <= '0;
`ifdef FJC_ABORT_EN
            aborted    <= 1'b0;
`endif
        end else begin
            join_pulse <= 1'b0;
            done       <= 1'b0;
`ifdef FJC_ABORT_EN
            aborted    <= 1'b0;
`endif
            for (int unsigned i = 0; i < NUM_CH; i++)
                if (ch_cnt[i] != '0) ch_cnt[i] <= ch_cnt[i] - 1'b1;
            if (tail_cnt != '0) tail_cnt <= tail_cnt - 1'b1;

            case (state)
                IDLE: if (start) begin
                    mode_q   <= mode;
                    tail_len <= tail_dur;
                    for (int unsigned i = 0; i < NUM_CH; i++)
                        ch_cnt[i] <= dur[i*CNT_W +: CNT_W];
                    state <= FORK;
                end
                // A zero-length tail is complete at join time, so TAIL is skipped.
                FORK: if (join_ok) begin
                    join_pulse <= 1'b1;
                    if (tail_len != '0) begin
                        tail_cnt <= tail_len;
                        state    <= TAIL;
                    end else if (all_cmp) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= DRAIN;
                    end
                end
                TAIL: if (tail_cnt <= CNT_W'(1)) begin
                    if (all_cmp) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: if (all_cmp) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef FJC_ABORT_EN
            if (abort && state != IDLE) begin
                for (int unsigned i = 0; i < NUM_CH; i++) ch_cnt[i] <= '0;
                tail_cnt   <= '0;
                join_pulse <= 1'b0;
                done       <= 1'b0;
                aborted    <= 1'b1;
                state      <= IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Self-checking bench for fork_join_ctrl: directed table, hand sequences, randomized launches vs timeline model.
module tb_fork_join_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [23:0] dur;
    logic [7:0]  tail_dur;
    logic        busy;
    logic [2:0]  ch_active;
    logic [2:0]  ch_done;
    logic        join_pulse;
    logic        tail_active;
    logic        tail_done;
    logic        done;
`ifdef FJC_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    int checks = 0;
    int errors = 0;

    fork_join_ctrl #(.NUM_CH(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dur(dur), .tail_dur(tail_dur),
`ifdef FJC_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .busy(busy), .ch_active(ch_active), .ch_done(ch_done), .join_pulse(join_pulse),
        .tail_active(tail_active), .tail_done(tail_done), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] observed();
        return {busy, ch_active, ch_done, join_pulse, tail_active, tail_done, done};
    endfunction

    // Launch one job set (cycle 0 = start cycle) and compare every cycle up to the done cycle
    // against a timeline derived from the join/tail/drain rules.
    task automatic launch(input logic [1:0] m, input int d0, input int d1, input int d2, input int td,
                          input bit b2b, input bit spam, output int jc, output int tc, output int dc);
        int d[3];
        int c, jj, e, mx, done_at;
        logic [10:0] ex;
        d[0] = d0; d[1] = d1; d[2] = d2;
        jj = (m == 2'b01) ? 1000 : 1;
        mx = 0;
        for (int i = 0; i < 3; i++) begin
            c = (d[i] == 0) ? 1 : d[i];
            if (m == 2'b01) jj = (c < jj) ? c : jj;
            else if (m != 2'b10) jj = (c > jj) ? c : jj;
            if (d[i] > mx) mx = d[i];
        end
        e = jj + td;
        done_at = ((e > mx) ? e : mx) + 1;
        jc = -1; tc = -1; dc = -1;
        if (!b2b) begin
            @(negedge clk);
            chk("idle_before_start", int'(observed()), 0);
        end
        start = 1'b1; mode = m; tail_dur = 8'(td);
        dur = {8'(d2), 8'(d1), 8'(d0)};
        for (int r = 1; r <= done_at; r++) begin
            @(negedge clk);
            ex = '0;
            ex[10] = (r < done_at);
            for (int i = 0; i < 3; i++) begin
                ex[7+i] = (d[i] >= 1 && r <= d[i]);
                ex[4+i] = (d[i] >= 1 && r == d[i]);
            end
            ex[3] = (r == jj + 1);
            ex[2] = (td > 0 && r > jj && r <= jj + td);
            ex[1] = (td > 0 && r == jj + td);
            ex[0] = (r == done_at);
            chk($sformatf("cycle%0d_outputs", r), int'(observed()), int'(ex));
            if (join_pulse && jc < 0) jc = r;
            if (tail_done && tc < 0) tc = r;
            if (done && dc < 0) dc = r;
            start = 1'b0;
            if (spam && r < done_at) begin
                start    = 1'($urandom_range(0, 1));
                mode     = 2'($urandom_range(0, 3));
                dur      = 24'($urandom);
                tail_dur = 8'($urandom);
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [1:0] m;
        int d0, d1, d2, td;
        bit spam;
        int ej, et, ed;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int jc, tc, dc, cnt;
        bit prev_launch;
        tbl[0] = '{2'b01, 2, 4, 6, 3, 1'b0, 3, 5, 7};
        tbl[1] = '{2'b00, 2, 4, 6, 3, 1'b0, 7, 9, 10};
        tbl[2] = '{2'b10, 2, 4, 6, 3, 1'b0, 2, 4, 7};
        tbl[3] = '{2'b00, 0, 0, 0, 0, 1'b0, 2, -1, 2};
        tbl[4] = '{2'b11, 2, 4, 6, 3, 1'b1, 7, 9, 10};
        tbl[5] = '{2'b01, 0, 5, 0, 2, 1'b0, 2, 3, 6};
        tbl[6] = '{2'b00, 255, 1, 0, 1, 1'b0, 256, 256, 257};

        rst_n = 1'b0; start = 1'b0; mode = '0; dur = '0; tail_dur = '0;
`ifdef FJC_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(observed()), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            launch(tbl[k].m, tbl[k].d0, tbl[k].d1, tbl[k].d2, tbl[k].td, 1'b0, tbl[k].spam, jc, tc, dc);
            chk($sformatf("tbl%0d_join_cycle", k), jc, tbl[k].ej);
            chk($sformatf("tbl%0d_tail_done_cycle", k), tc, tbl[k].et);
            chk($sformatf("tbl%0d_done_cycle", k), dc, tbl[k].ed);
        end

        // Back-to-back: start in the done cycle of an all-zero launch is accepted.
        launch(2'b01, 0, 0, 0, 0, 1'b0, 1'b0, jc, tc, dc);
        chk("b2b_first_done", dc, 2);
        launch(2'b00, 1, 3, 0, 2, 1'b1, 1'b0, jc, tc, dc);
        chk("b2b_second_done", dc, 6);

        // Synchronous reset mid-run aborts silently.
        @(negedge clk);
        start = 1'b1; mode = 2'b00; dur = {8'd6, 8'd4, 8'd2}; tail_dur = 8'd3;
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", int'(observed()), 0);
        rst_n = 1'b1;
        cnt = 0;
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            cnt += int'(done) + int'(join_pulse) + int'(tail_done) + int'(busy);
        end
        chk("post_reset_quiet", cnt, 0);

`ifdef FJC_ABORT_EN
        @(negedge clk);
        start = 1'b1; mode = 2'b01; dur = {8'd6, 8'd4, 8'd2}; tail_dur = 8'd3;
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_pulse", int'(aborted), 1);
        chk("abort_busy", int'(busy), 0);
        cnt = 0;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            cnt += int'(done) + int'(tail_done) + int'(aborted);
        end
        chk("abort_quiet", cnt, 0);
`endif

        prev_launch = 1'b0;
        for (int k = 0; k < 40; k++) begin
            bit b2b;
            b2b = prev_launch && ($urandom_range(0, 1) == 1);
            launch(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), b2b,
                   1'($urandom_range(0, 1)), jc, tc, dc);
            prev_launch = 1'b1;
        end

        @(negedge clk);
        chk("final_idle", int'(observed()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fork_join_ctrl.md
Name: fork_join_ctrl

Overview:
- Synthesizable concurrent-job launcher with programmable join semantics.
- One `start` forks NUM_CH parallel timed jobs, each a countdown of programmable length.
- Waits per join mode (ALL / ANY / NONE), then runs one sequential tail job.
- Returns to idle only when the tail and all forked jobs have finished.
- Used as a sequencing primitive wherever parallel timed phases must be joined before a follow-on phase.

Parameters:
- NUM_CH, 3, number of parallel job channels (1..16).
- CNT_W, 8, width of each duration field in cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- mode  in  2  join mode, latched at start: 00 ALL, 01 ANY, 10 NONE, 11 reserved (treated as ALL).
- dur  in  NUM_CH*CNT_W  per-channel duration; channel i uses bits [i*CNT_W +: CNT_W]; latched at start.
- tail_dur  in  CNT_W  tail job duration; latched at start.
- busy  out  1  high whenever state is not IDLE.
- ch_active  out  NUM_CH  channel i is counting.
- ch_done  out  NUM_CH  one-cycle pulse in channel i's last active cycle.
- join_pulse  out  1  one-cycle pulse when the join condition has been met.
- tail_active  out  1  tail job is counting.
- tail_done  out  1  one-cycle pulse in the tail's last active cycle.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset: state IDLE; all counters 0; every output 0.
- Reset asserted mid-operation aborts everything at that edge; no pulses are emitted.
- States: IDLE, FORK, TAIL, DRAIN.
- Launch: `start` in IDLE at cycle T latches mode and all durations, loads the channel counters, and moves to FORK at T+1. `start` outside IDLE is ignored.
- Channel with D>=1:
  - ch_active high for cycles T+1..T+D.
  - ch_done pulses at T+D.
- Channel with D=0: disabled. Never active, no ch_done, counts as complete from T+1.
- Join condition, evaluated in FORK:
  - ALL: every channel complete.
  - ANY: at least one channel complete.
  - NONE: true unconditionally.
  - If all channels are disabled, the condition is true at T+1 in every mode.
- Condition first true in cycle J:
  - join_pulse at J+1; state TAIL at J+1.
  - tail_active for J+1..J+tail_dur; tail_done at J+tail_dur.
  - tail_dur=0: no tail_active, no tail_done; the tail counts as complete at J+1.
- Channels keep counting through TAIL and DRAIN; they are never cut short by the join.
- Leaving TAIL:
  - Tail complete and all channels complete: IDLE, with done=1 on the IDLE-entry cycle.
  - Tail complete, channels still running: DRAIN.
  - DRAIN goes to IDLE (done pulse) the cycle after the last ch_done.
- busy timing: busy=0 in the done cycle. A start in that same cycle is accepted, giving back-to-back operation.
- Simultaneous ch_done pulses are allowed and cause no extra join_pulse. join_pulse fires exactly once per launch.
- Counter width: CNT_W with no wrap. Maximum duration is 2^CNT_W-1 cycles.

Optional Feature:
- Macro: FJC_ABORT_EN.
- When defined, the block adds:
  - input `abort` (1 bit).
  - output `aborted` (1-bit pulse).
- `abort` high in any non-IDLE state:
  - clears all channel and tail counters at that edge;
  - moves to IDLE and pulses `aborted` in the next cycle;
  - suppresses done, join_pulse, ch_done and tail_done from that cycle on.
- `abort` in IDLE is ignored. `abort` and `start` together in IDLE: start wins.
- When not defined, both ports are absent and behaviour is exactly as above.

Test Plan:
- ANY, dur={2,4,6}, tail_dur=3, start at cycle 0 -> ch_done0@2, join_pulse@3, tail_active 3-5, ch_done1@4, tail_done@5, ch_done2@6, done@7.
- ALL, same durations and tail -> join_pulse@7, tail_active 7-9, tail_done@9, done@10, busy high 1-9.
- NONE, same durations and tail -> join_pulse@2, tail_done@4, state DRAIN 5-6, done@7.
- All dur=0, tail_dur=0, any mode -> join_pulse@2, done@2, no ch_done or tail_done. Then start@2 -> second launch accepted, busy@3.
- start repeated while busy, and mode=11 -> extra starts ignored, exactly one join_pulse, 11 behaves as ALL. rst_n=0 at cycle 3 of an ALL run -> all outputs 0 at cycle 4, no done pulse.
- FJC_ABORT_EN defined: abort@3 during the first scenario -> aborted@4, busy 0@4, no tail_done or done. Without the macro, the block elaborates with no `abort`/`aborted` ports.
